hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline hazard controller for the five-stage RV32I core. Each cycle it drives the `bubbleX`/`flushX` controls of every segment register (IF/ID, ID/EX, EX/MEM, MEM/WB and the PC). It sequences three hazard types:
- data-cache miss stalls, using a req/ack handshake;
- branch/jump redirects, including mispredicts of the BTB `taken` bit;
- load-use interlocks.

It also keeps hazard performance counters.

## Interface
Parameters:
- `CNT_W`, 32, width of each performance counter.

Ports:
- `clk`  in  1  core clock; all state updates on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `miss_req`  in  1  D-cache reports a miss for the access in MEM
- `miss_ack`  in  1  D-cache refill complete; the data is valid this cycle
- `br_EX`  in  1  branch in EX resolved taken
- `taken_EX`  in  1  BTB prediction carried with the EX instruction
- `jalr_EX`  in  1  JALR in EX
- `jal_ID`  in  1  JAL decoded in ID
- `load_EX`  in  1  instruction in EX is a load
- `rd_EX`  in  5  destination register of the EX instruction
- `rs1_ID`, `rs2_ID`  in  5  source registers of the ID instruction
- `rs1_use_ID`, `rs2_use_ID`  in  1  source is actually read
- `cnt_clr`  in  1  synchronous clear of all counters
- `bubbleF..bubbleW`  out  1 each  hold the segment register (F = PC)
- `flushF..flushW`  out  1 each  zero the segment register
- `redirect`  out  1  PC mux selects the redirect target this cycle
- `stall_cnt`, `mispred_cnt`, `loaduse_cnt`, `miss_cnt`  out  `CNT_W`  performance counters

## Operation
FSM states:
- RUN: normal operation.
- MISS: waiting for the D-cache refill.
- DRAIN: one cycle that replays a redirect that was held during MISS.

Transitions:
- RUN→MISS on `miss_req`.
- MISS→RUN on `miss_ack` when no redirect is pending.
- MISS→DRAIN on `miss_ack` when a redirect is pending.
- DRAIN→RUN unconditionally.

Output rules, in priority order:
1. MISS, or RUN with `miss_req`: `bubbleF..bubbleM`=1, `flushW`=1. All other flushes 0. `redirect`=0.
2. Redirect (`mispred` = `br_EX`^`taken_EX`, or `jalr_EX`), or state DRAIN: `flushD`=`flushE`=1, `redirect`=1.
3. Load-use hazard (`load_EX` & `rd_EX`≠0 & ((`rs1_use_ID` & `rs1_ID`==`rd_EX`) | (`rs2_use_ID` & `rs2_ID`==`rd_EX`))): `bubbleF`=`bubbleD`=1, `flushE`=1.
4. `jal_ID` (unpredicted): `flushD`=1, `redirect`=1.
5. Otherwise all outputs are 0.

Redirect during a miss:
- A redirect asserted in the same cycle as `miss_req`, or during MISS, sets `pend_redir`.
- `pend_redir` is cleared on leaving DRAIN.
- Multiple redirects while pending collapse into one; EX is frozen, so it is the same instruction.

`miss_ack` outside MISS is ignored. `miss_req` and `miss_ack` high together in RUN: enter MISS, and the ack is not consumed.

Counters, wrapping modulo 2^`CNT_W`:
- `stall_cnt` +1 every cycle in MISS.
- `miss_cnt` +1 on each RUN→MISS.
- `mispred_cnt` +1 per redirect applied, counted in RUN or DRAIN, not while held.
- `loaduse_cnt` +1 per interlock cycle.
- `cnt_clr` takes priority over increments.

## Timing
- All hazard outputs are combinational from the current state and inputs, valid within the same cycle.
- State, `pend_redir` and counters are registered.
- While `rst_n`=0:
  - state=RUN, `pend_redir`=0, counters=0;
  - `flushF..flushW`=1, all bubbles=0, `redirect`=0.
- Reset asserted mid-MISS aborts the miss immediately.
- Latencies:
  - Load-use costs exactly 1 bubble cycle.
  - Mispredict costs 2 flushed slots.
  - A miss stalls from the `miss_req` cycle through the `miss_ack` cycle inclusive.
  - A held redirect costs 1 extra cycle (DRAIN).

## Structure
- Shared package `hazard_pkg`: state enum (RUN/MISS/DRAIN) and the 5-bit register index width.
- One natural sub-module, `hazard_perf_cnt`: four counters with clear, parameterised by `CNT_W`.
- FSM and priority encoder stay in `hazard_ctrl`. Target size is about 200 lines.

## Test plan
- Load-use: `load_EX`=1, `rd_EX`=5, `rs1_ID`=5, `rs1_use_ID`=1 → `bubbleF`=`bubbleD`=`flushE`=1 for one cycle, then `loaduse_cnt`=1. Repeat with `rd_EX`=0 → no stall.
- Mispredict: `br_EX`=1, `taken_EX`=0 → `flushD`=`flushE`=`redirect`=1, `mispred_cnt`=1. `br_EX`=`taken_EX`=1 → no flush.
- Miss: `miss_req` held, `miss_ack` after 10 cycles → `bubbleF..bubbleM`=1 and `flushW`=1 for 11 cycles, `stall_cnt`=10, `miss_cnt`=1, back in RUN.
- Redirect during miss: `jalr_EX`=1 in MISS cycle 3, ack in cycle 6 → no `redirect` while in MISS; DRAIN cycle gives `flushD`=`flushE`=`redirect`=1 once; `mispred_cnt`=1.
- Priority: `miss_req`, `br_EX` mispredict and load-use all in one cycle → only the miss response appears; the redirect is replayed in DRAIN; `loaduse_cnt` is unchanged during MISS.
- Reset: assert `rst_n`=0 in MISS with `pend_redir`=1 → all flushes=1 immediately. On release, state=RUN and counters=0; `cnt_clr` with a concurrent increment → counter reads 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller:
// FSM state encoding and register-index width.
package hazard_pkg;

   localparam int REG_W = 5;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_MISS  = 2'd1,
      ST_DRAIN = 2'd2
   } hz_state_e;

endpackage

// File: rtl/hazard_perf_cnt.sv
// Hazard performance counters: stall, mispredict, load-use, miss.
// Ports: clk, rst_n, clr, four inc_* strobes, four CNT_W-wide counts.
module hazard_perf_cnt #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             inc_stall,
   input  logic             inc_mispred,
   input  logic             inc_loaduse,
   input  logic             inc_miss,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] mispred_cnt,
   output logic [CNT_W-1:0] loaduse_cnt,
   output logic [CNT_W-1:0] miss_cnt
);

   localparam int PAD = CNT_W - 1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt   <= '0;
         mispred_cnt <= '0;
         loaduse_cnt <= '0;
         miss_cnt    <= '0;
      end else if (clr) begin
         stall_cnt   <= '0;
         mispred_cnt <= '0;
         loaduse_cnt <= '0;
         miss_cnt    <= '0;
      end else begin
         stall_cnt   <= stall_cnt   + {{PAD{1'b0}}, inc_stall};
         mispred_cnt <= mispred_cnt + {{PAD{1'b0}}, inc_mispred};
         loaduse_cnt <= loaduse_cnt + {{PAD{1'b0}}, inc_loaduse};
         miss_cnt    <= miss_cnt    + {{PAD{1'b0}}, inc_miss};
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard controller: D-cache miss stall FSM,
// redirect/mispredict flushes, load-use interlock, perf counters.
// Ports: hazard inputs from EX/ID/MEM, bubble*/flush* per segment
// register (F = PC), redirect select, four performance counters.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             miss_req,
   input  logic             miss_ack,
   input  logic             br_EX,
   input  logic             taken_EX,
   input  logic             jalr_EX,
   input  logic             jal_ID,
   input  logic             load_EX,
   input  logic [REG_W-1:0] rd_EX,
   input  logic [REG_W-1:0] rs1_ID,
   input  logic [REG_W-1:0] rs2_ID,
   input  logic             rs1_use_ID,
   input  logic             rs2_use_ID,
   input  logic             cnt_clr,
   output logic             bubbleF,
   output logic             bubbleD,
   output logic             bubbleE,
   output logic             bubbleM,
   output logic             bubbleW,
   output logic             flushF,
   output logic             flushD,
   output logic             flushE,
   output logic             flushM,
   output logic             flushW,
   output logic             redirect,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] mispred_cnt,
   output logic [CNT_W-1:0] loaduse_cnt,
   output logic [CNT_W-1:0] miss_cnt
);

   hz_state_e state;
   logic      pend_redir;

   logic redir_req;
   logic lu_hit;
   logic st_run;
   logic st_drain;
   logic in_miss;
   logic do_redir;
   logic do_lu;
   logic do_jal;
   logic pend_nxt;

   assign redir_req = (br_EX ^ taken_EX) | jalr_EX;

   assign lu_hit = load_EX & (rd_EX != '0) &
                   ((rs1_use_ID & (rs1_ID == rd_EX)) |
                    (rs2_use_ID & (rs2_ID == rd_EX)));

   assign st_run   = (state == ST_RUN);
   assign st_drain = (state == ST_DRAIN);

   // The miss freezes everything from its request cycle on,
   // so a miss in RUN outranks every other hazard.
   assign in_miss  = (state == ST_MISS) | (st_run & miss_req);
   assign do_redir = ~in_miss & (redir_req | st_drain);
   assign do_lu    = ~in_miss & ~do_redir & lu_hit;
   assign do_jal   = ~in_miss & ~do_redir & ~lu_hit & jal_ID;

   // EX is frozen while waiting, so any redirect seen during the
   // miss (including the ack cycle) is the one to replay.
   assign pend_nxt = pend_redir | redir_req;

   always_comb begin
      bubbleF  = 1'b0;
      bubbleD  = 1'b0;
      bubbleE  = 1'b0;
      bubbleM  = 1'b0;
      bubbleW  = 1'b0;
      flushF   = 1'b0;
      flushD   = 1'b0;
      flushE   = 1'b0;
      flushM   = 1'b0;
      flushW   = 1'b0;
      redirect = 1'b0;
      if (!rst_n) begin
         flushF = 1'b1;
         flushD = 1'b1;
         flushE = 1'b1;
         flushM = 1'b1;
         flushW = 1'b1;
      end else begin
         unique case (1'b1)
            in_miss: begin
               bubbleF = 1'b1;
               bubbleD = 1'b1;
               bubbleE = 1'b1;
               bubbleM = 1'b1;
               flushW  = 1'b1;
            end
            do_redir: begin
               flushD   = 1'b1;
               flushE   = 1'b1;
               redirect = 1'b1;
            end
            do_lu: begin
               bubbleF = 1'b1;
               bubbleD = 1'b1;
               flushE  = 1'b1;
            end
            do_jal: begin
               flushD   = 1'b1;
               redirect = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_RUN;
         pend_redir <= 1'b0;
      end else begin
         unique case (state)
            ST_RUN: begin
               if (miss_req) begin
                  state      <= ST_MISS;
                  pend_redir <= redir_req;
               end
            end
            ST_MISS: begin
               pend_redir <= pend_nxt;
               if (miss_ack)
                  state <= pend_nxt ? ST_DRAIN : ST_RUN;
            end
            ST_DRAIN: begin
               state      <= ST_RUN;
               pend_redir <= 1'b0;
            end
            default: begin
               state      <= ST_RUN;
               pend_redir <= 1'b0;
            end
         endcase
      end
   end

   hazard_perf_cnt #(
      .CNT_W(CNT_W)
   ) u_perf (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (cnt_clr),
      .inc_stall  (state == ST_MISS),
      .inc_mispred(do_redir),
      .inc_loaduse(do_lu),
      .inc_miss   (st_run & miss_req),
      .stall_cnt  (stall_cnt),
      .mispred_cnt(mispred_cnt),
      .loaduse_cnt(loaduse_cnt),
      .miss_cnt   (miss_cnt)
   );

endmodule
